// File: rtl/mac_scan_scheduler_if.sv
// Header-tap, comparator and result signals shared by mac_scan_scheduler and its environment.
// master = header tap / comparator side, slave = scheduler side.
interface mac_scan_scheduler_if #(
  parameter int NUM_ENTRIES = 4,
  parameter int IDX_W       = $clog2(NUM_ENTRIES)
);
  logic             hdr_valid;
  logic [31:0]      hdr_data;
  logic             hdr_last;
  logic             hdr_ready;
  logic             cmp_clear;
  logic [47:0]      cmp_flagged_mac;
  logic [31:0]      cmp_data_in;
  logic             cmp_match;
  logic             result_valid;
  logic             result_hit;
  logic [IDX_W-1:0] result_idx;
  logic             busy;

  modport master (
    output hdr_valid, hdr_data, hdr_last, cmp_match,
    input  hdr_ready, cmp_clear, cmp_flagged_mac, cmp_data_in,
    input  result_valid, result_hit, result_idx, busy
  );

  modport slave (
    input  hdr_valid, hdr_data, hdr_last, cmp_match,
    output hdr_ready, cmp_clear, cmp_flagged_mac, cmp_data_in,
    output result_valid, result_hit, result_idx, busy
  );
endinterface

// File: rtl/mac_scan_scheduler.sv
// Time-shares one MAC comparator over a table of flagged MACs by replaying a captured header window.
// Optional per-entry saturating hit counters are enabled with `define MAC_SCAN_HIT_COUNT_EN.
module mac_scan_scheduler #(
  parameter int NUM_ENTRIES = 4,
  parameter int WINDOW      = 4,
  parameter int DRAIN       = 4,
  parameter int IDX_W       = $clog2(NUM_ENTRIES)
) (
  input  logic                 clk,
  input  logic                 n_rst,
  input  logic                 cfg_we,
  input  logic [IDX_W-1:0]     cfg_addr,
  input  logic [47:0]          cfg_mac,
  input  logic                 cfg_en,
`ifdef MAC_SCAN_HIT_COUNT_EN
  input  logic [IDX_W-1:0]     cnt_addr,
  output logic [15:0]          cnt_data,
`endif
  mac_scan_scheduler_if.slave  bus
);

  localparam int MAXC = (WINDOW > DRAIN) ? WINDOW : DRAIN;
  localparam int CW   = $clog2(MAXC + 1);

  typedef enum logic [2:0] {
    ST_CAPTURE, ST_CLEAR, ST_REPLAY, ST_DRAIN, ST_CHECK, ST_RESULT
  } state_e;

  state_e           state_q, state_d;
  logic [IDX_W-1:0] ptr_q, ptr_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [CW-1:0]    wcnt_q, wcnt_d;
  logic [31:0]      buf_q [WINDOW];
  logic [31:0]      buf_d [WINDOW];
  logic             hit_q, hit_d;
  logic [47:0]      mac_q [NUM_ENTRIES];
  logic [NUM_ENTRIES-1:0] en_q;

  logic             hdr_ready_q, hdr_ready_d;
  logic             busy_q, busy_d;
  logic             cmp_clear_q, cmp_clear_d;
  logic [47:0]      cmp_mac_q, cmp_mac_d;
  logic [31:0]      cmp_data_q, cmp_data_d;
  logic             res_valid_q, res_valid_d;
  logic             res_hit_q, res_hit_d;
  logic [IDX_W-1:0] res_idx_q, res_idx_d;

  logic             acc_s;
  logic [IDX_W:0]   first_s;
  logic [IDX_W:0]   next_s;

  // Lowest enabled index >= from, returned as {found, index}.
  function automatic logic [IDX_W:0] first_enabled(input logic [NUM_ENTRIES-1:0] en,
                                                   input int from);
    logic [IDX_W:0] res;
    res = '0;
    for (int i = NUM_ENTRIES - 1; i >= 0; i--) begin
      res = (en[i] && (i >= from)) ? {1'b1, IDX_W'(i)} : res;
    end
    return res;
  endfunction

  assign acc_s   = bus.hdr_valid & hdr_ready_q;
  assign first_s = first_enabled(en_q, 0);
  assign next_s  = first_enabled(en_q, int'(ptr_q) + 1);

  // Next-state logic; output registers are loaded from the state being entered.
  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    cnt_d     = cnt_q;
    wcnt_d    = wcnt_q;
    buf_d     = buf_q;
    hit_d     = hit_q;
    res_hit_d = res_hit_q;
    res_idx_d = res_idx_q;

    case (state_q)
      ST_CAPTURE: begin
        if (acc_s) begin
          for (int i = 0; i < WINDOW; i++) begin
            if (CW'(i) == wcnt_q) begin
              buf_d[i] = bus.hdr_data;
            end else if (bus.hdr_last && (CW'(i) > wcnt_q)) begin
              buf_d[i] = 32'h0000_0000;
            end else begin
              buf_d[i] = buf_q[i];
            end
          end
          if (bus.hdr_last) begin
            wcnt_d = '0;
            if (first_s[IDX_W]) begin
              ptr_d   = first_s[IDX_W-1:0];
              state_d = ST_CLEAR;
            end else begin
              res_hit_d = 1'b0;
              res_idx_d = '0;
              state_d   = ST_RESULT;
            end
          end else if (wcnt_q < CW'(WINDOW)) begin
            wcnt_d = wcnt_q + CW'(1);
          end else begin
            wcnt_d = wcnt_q;
          end
        end else begin
          state_d = ST_CAPTURE;
        end
      end
      ST_CLEAR: begin
        hit_d   = 1'b0;
        cnt_d   = '0;
        state_d = ST_REPLAY;
      end
      ST_REPLAY: begin
        hit_d = hit_q | bus.cmp_match;
        if (cnt_q == CW'(WINDOW - 1)) begin
          cnt_d   = '0;
          state_d = ST_DRAIN;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      ST_DRAIN: begin
        hit_d = hit_q | bus.cmp_match;
        if (cnt_q == CW'(DRAIN - 1)) begin
          cnt_d   = '0;
          state_d = ST_CHECK;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      ST_CHECK: begin
        if (hit_q) begin
          res_hit_d = 1'b1;
          res_idx_d = ptr_q;
          state_d   = ST_RESULT;
        end else if (next_s[IDX_W]) begin
          ptr_d   = next_s[IDX_W-1:0];
          state_d = ST_CLEAR;
        end else begin
          res_hit_d = 1'b0;
          res_idx_d = '0;
          state_d   = ST_RESULT;
        end
      end
      ST_RESULT: begin
        state_d = ST_CAPTURE;
      end
      default: begin
        state_d = ST_CAPTURE;
      end
    endcase

    hdr_ready_d = (state_d == ST_CAPTURE);
    busy_d      = (state_d != ST_CAPTURE);
    cmp_clear_d = (state_d == ST_CLEAR);
    res_valid_d = (state_d == ST_RESULT);
    cmp_mac_d   = (state_d == ST_CLEAR) ? mac_q[ptr_d] : cmp_mac_q;
    cmp_data_d  = 32'h0000_0000;
    for (int i = 0; i < WINDOW; i++) begin
      if ((state_d == ST_REPLAY) && (CW'(i) == cnt_d)) begin
        cmp_data_d = buf_q[i];
      end else begin
        cmp_data_d = cmp_data_d;
      end
    end
  end

  // Scheduler state and registered outputs.
  always_ff @(posedge clk) begin
    if (!n_rst) begin
      state_q     <= ST_CAPTURE;
      ptr_q       <= '0;
      cnt_q       <= '0;
      wcnt_q      <= '0;
      hit_q       <= 1'b0;
      for (int i = 0; i < WINDOW; i++) buf_q[i] <= 32'h0000_0000;
      hdr_ready_q <= 1'b1;
      busy_q      <= 1'b0;
      cmp_clear_q <= 1'b0;
      cmp_mac_q   <= 48'h0;
      cmp_data_q  <= 32'h0000_0000;
      res_valid_q <= 1'b0;
      res_hit_q   <= 1'b0;
      res_idx_q   <= '0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      cnt_q       <= cnt_d;
      wcnt_q      <= wcnt_d;
      hit_q       <= hit_d;
      buf_q       <= buf_d;
      hdr_ready_q <= hdr_ready_d;
      busy_q      <= busy_d;
      cmp_clear_q <= cmp_clear_d;
      cmp_mac_q   <= cmp_mac_d;
      cmp_data_q  <= cmp_data_d;
      res_valid_q <= res_valid_d;
      res_hit_q   <= res_hit_d;
      res_idx_q   <= res_idx_d;
    end
  end

  // Flagged-MAC table; writes are accepted in every state.
  always_ff @(posedge clk) begin
    if (!n_rst) begin
      for (int i = 0; i < NUM_ENTRIES; i++) mac_q[i] <= 48'h0;
      en_q <= '0;
    end else if (cfg_we) begin
      mac_q[cfg_addr] <= cfg_mac;
      en_q[cfg_addr]  <= cfg_en;
    end else begin
      en_q <= en_q;
    end
  end

`ifdef MAC_SCAN_HIT_COUNT_EN
  logic [15:0] hits_q [NUM_ENTRIES];

  // Saturating per-entry hit counters, bumped once per hitting result.
  always_ff @(posedge clk) begin
    if (!n_rst) begin
      for (int i = 0; i < NUM_ENTRIES; i++) hits_q[i] <= 16'h0000;
    end else if ((state_q == ST_RESULT) && res_hit_q && (hits_q[res_idx_q] != 16'hFFFF)) begin
      hits_q[res_idx_q] <= hits_q[res_idx_q] + 16'h0001;
    end else begin
      hits_q[res_idx_q] <= hits_q[res_idx_q];
    end
  end

  assign cnt_data = hits_q[cnt_addr];
`endif

  assign bus.hdr_ready       = hdr_ready_q;
  assign bus.busy            = busy_q;
  assign bus.cmp_clear       = cmp_clear_q;
  assign bus.cmp_flagged_mac = cmp_mac_q;
  assign bus.cmp_data_in     = cmp_data_q;
  assign bus.result_valid    = res_valid_q;
  assign bus.result_hit      = res_hit_q;
  assign bus.result_idx      = res_idx_q;

endmodule
